// File: rtl/router_pkg.sv
// Shared types and default sizing for the router output-port logic.
package router_pkg;

  // Output-port ownership: free for arbitration, or held by one requester
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int W_DEF       = 8;
  localparam int CREDITS_DEF = 4;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick
  import router_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] win_idx
);

  // Scan N positions starting at ptr; the first hit wins
  always_comb begin : scan
    logic          found;
    logic [IW:0]   pos;
    logic [IW-1:0] idx;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      idx = pos[IW-1:0];
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port scheduler: packet-locked round-robin grant with credit flow control.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               in_valid,
  input  logic [N_REQ-1:0]               in_tail,
  input  logic [N_REQ*W-1:0]             in_data,
  output logic [N_REQ-1:0]               in_ready,
  output logic [N_REQ-1:0]               grant,
  output logic                           out_valid,
  output logic [W-1:0]                   out_data,
  output logic                           out_tail,
  input  logic                           credit_ret,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           credit_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ-1);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    rr_ptr, ptr_nxt;
  logic [N_REQ-1:0] pick_winner;
  logic [IW-1:0]    pick_idx;
  logic             credit_ok;
  logic             xfer;
  logic [W-1:0]     xfer_data;
  logic             xfer_tail;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .winner  (pick_winner),
    .win_idx (pick_idx)
  );

  // Readiness depends only on ownership and credit, never on in_valid
  assign credit_ok = (credit_cnt != '0);
  assign in_ready  = grant & {N_REQ{credit_ok}};
  assign xfer      = |(in_valid & in_ready);

  // One-hot grant selects the owner's flit onto the link path
  always_comb begin
    xfer_data = '0;
    xfer_tail = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        xfer_data = in_data[i*W +: W];
        xfer_tail = in_tail[i];
      end
    end
  end

  // Ownership FSM: arbitrate when idle, hold until the tail flit leaves
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    ptr_nxt   = rr_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = LOCKED;
          grant_nxt = pick_winner;
          owner_nxt = pick_idx;
        end
      end
      LOCKED: begin
        // req dropping mid-packet is deliberately ignored here
        if (xfer && xfer_tail) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + IW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // FSM and arbitration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      owner  <= owner_nxt;
      rr_ptr <= ptr_nxt;
    end
  end

  // Credit counter: a send and a return in one cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({xfer, credit_ret})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CRED_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Link output register, one cycle behind the accepted flit
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= xfer;
      out_tail  <= xfer & xfer_tail;
      if (xfer) begin
        out_data <= xfer_data;
      end
    end
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port scheduler for the router: shares one output link among `N_REQ` input requesters on a packet basis, with round-robin fairness and credit-based flow control toward the downstream buffer. It sits between the input-port route-decision logic (which raises `req` toward this output) and the output link register. Each grant is held from head flit to tail flit, and no flit is sent without a downstream credit.

## Interface

Parameters:
- `N_REQ`, 4: number of requesting input ports (≥2).
- `W`, 8: flit data width.
- `CREDITS`, 4: downstream buffer depth; the credit counter's reset value.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_REQ`: requester i has a packet routed to this output.
- `in_valid`, in, `N_REQ`: flit i is valid.
- `in_tail`, in, `N_REQ`: flit i is the last flit of its packet.
- `in_data`, in, `N_REQ*W`: flit payloads; requester i uses bits `[i*W +: W]`.
- `in_ready`, out, `N_REQ`: flit i is accepted this cycle.
- `grant`, out, `N_REQ`: registered one-hot owner of the link; all-zero when idle.
- `out_valid`, out, 1: registered flit valid toward the link.
- `out_data`, out, `W`: registered flit payload.
- `out_tail`, out, 1: registered tail marker.
- `credit_ret`, in, 1: downstream freed one buffer slot.
- `credit_cnt`, out, `$clog2(CREDITS+1)`: current credits.
- `credit_err`, out, 1: sticky flag for a credit return while the counter is at `CREDITS`.

## Operation

- The FSM has two states: `IDLE` and `LOCKED`.
- In `IDLE`, if `req != 0`, the round-robin pick takes the first set `req` bit at or after `rr_ptr`, wrapping around. Next cycle: `grant` is one-hot on the winner and the state is `LOCKED`.
- In `LOCKED`, `in_ready[i] = grant[i] & (credit_cnt != 0)`. A transfer happens when `in_valid[i] & in_ready[i]`.
- Each transfer decrements the credit count, and the next cycle drives `out_valid`, `out_data` and `out_tail` from the source flit.
- A transfer with `in_tail` set ends the packet. Next cycle: state is `IDLE`, `grant` is 0, and `rr_ptr` is (winner+1) mod `N_REQ`.
- `req` deasserting mid-packet is ignored; the lock is released only by a tail transfer.
- Credit arithmetic:
  - Transfer plus `credit_ret` in the same cycle leaves the count unchanged.
  - `credit_ret` alone increments the count, saturating at `CREDITS`. A return at `CREDITS` sets `credit_err` and leaves the count unchanged.
  - A transfer is impossible at 0 credits because `in_ready` is gated.
- A single-flit packet (head = tail) is legal: `LOCKED` lasts exactly one transfer.

## Timing

- Reset values: state `IDLE`, `grant` 0, `rr_ptr` 0, `credit_cnt` = `CREDITS`, `credit_err` 0, `out_valid` 0, `out_tail` 0, `out_data` 0.
- `rst` asserted mid-packet aborts the packet. Everything returns to reset values on the next edge, and the partial packet is not completed.
- Request to first possible transfer: 1 cycle (grant is registered).
- Transfer to link output: 1 cycle.
- Tail transfer to next grant: 2 cycles. There is one `IDLE` cycle of arbitration, so there is exactly one bubble between packets.
- `in_ready` is combinational from `grant` and `credit_cnt` only. It never depends on `in_valid`.
- `credit_cnt` reflects a return on the cycle after the `credit_ret` pulse.

## Structure

- Shared package `router_pkg` holds:
  - the FSM state enum (`IDLE`, `LOCKED`);
  - default constants `N_REQ_DEF = 4`, `W_DEF = 8`, `CREDITS_DEF = 4`.
- One sub-module, `rr_pick`: purely combinational, with inputs `req[N]` and `ptr`. It outputs a one-hot `winner` and its index `win_idx`.
- The top level contains the FSM, the credit counter, the output register and the data mux.

## Test plan

- Reset, then idle 5 cycles: `grant=0`, `credit_cnt=4`, `out_valid=0` throughout.
- `req=4'b0110` at `rr_ptr=0`:
  - `grant=4'b0010` one cycle later;
  - a 3-flit packet `0xA1,0xA2,0xA3` appears on `out_data` on 3 consecutive cycles, with `out_tail` only on `0xA3`;
  - after the bubble, `grant=4'b0100`.
- All four requesters continuously sending 1-flit packets, with `credit_ret` looped back: the grant order is 0,1,2,3,0, with one idle cycle between each.
- 6-flit packet with no `credit_ret`: 4 flits transfer, then `in_ready=0` and `credit_cnt=0`. A `credit_ret` pulse resumes exactly one flit.
- Transfer and `credit_ret` in the same cycle keep `credit_cnt` at 3. `credit_ret` at `credit_cnt=4` sets `credit_err=1`, which stays set until `rst`.
- `rst` pulsed after flit 2 of a 4-flit packet: the next cycle shows `grant=0`, `credit_cnt=4` and `out_valid=0`, and a fresh `req` is arbitrated from `rr_ptr=0`.
